shift_engine: RTL and testbench
===============================

// Module: shift_engine
// PURPOSE
//  Parametrised multi-cycle shift/rotate register. It generalises the single-bit reset flop into a WIDTH-bit register.
//  - On start: parallel-loads a word, then applies one shift step per clock for a requested count.
//  - Reports completion with busy/done handshake. Serial I/O supports bit-serial datapaths (serial adder, sequential multiplier).
// PARAMETERS
//  WIDTH  8  data register width (>=2)
//  CNT_W  4  width of shift-amount input; max amount 2**CNT_W-1 (may exceed WIDTH)
// PORTS
//  clk    in   1        clock, all state updates on posedge
//  rst    in   1        reset, synchronous, active-high
//  start  in   1        request: load din and begin operation (sampled only when busy=0)
//  mode   in   3        op select, latched at accepted start
//  din    in   WIDTH    parallel load data
//  amt    in   CNT_W    number of shift steps, latched at accepted start
//  sin    in   1        serial input, sampled every shift step (mode 5 only)
//  q      out  WIDTH    register contents (registered)
//  sout   out  1        last bit shifted/rotated out (registered)
//  busy   out  1        high while shift steps remain
//  done   out  1        one-cycle completion pulse
// BEHAVIOUR
//  Reset: rst=1 at a posedge forces q=0, sout=0, busy=0, done=0, cnt=0, state IDLE.
//  - rst has priority over all inputs, including mid-operation; an aborted op never pulses done.
//  States: IDLE (busy=0), SHIFT (busy=1).
//  IDLE, start=1 at edge E0:
//  - q<=din, mode_r<=mode, cnt<=amt, sout<=0.
//  - amt>0: goto SHIFT, busy<=1, done<=0.
//  - amt==0: stay IDLE, done<=1 (pulse at E0+1 edge window), q=din.
//  IDLE, start=0: hold q/sout; done<=0.
//  SHIFT, each edge: one step on q per mode_r, sout<=bit leaving, cnt<=cnt-1.
//  - Step cnt==1: goto IDLE, busy<=0, done<=1.
//  - Final shift lands at edge E0+amt; done high for exactly the cycle after it.
//  - start is ignored while busy=1 (no queueing).
//  - start in the cycle done=1 is accepted (busy already 0). done then follows the new op's rules.
//  Modes (n=WIDTH-1):
//  - 0 LSL: q<={q[n-1:0],0}, sout=q[n]
//  - 1 LSR: q<={0,q[n:1]}, sout=q[0]
//  - 2 ASR: q<={q[n],q[n:1]}, sout=q[0]
//  - 3 ROL: q<={q[n-1:0],q[n]}, sout=q[n]
//  - 4 ROR: q<={q[0],q[n:1]}, sout=q[0]
//  - 5 SIR (serial-in right): q<={sin,q[n:1]}, sout=q[0]
//  - 6,7 reserved: q and sout hold each step; timing identical to other modes.
//  amt > WIDTH is legal: LSL/LSR saturate to 0, ASR to all-sign, rotates wrap modulo WIDTH.
//  No combinational path from inputs to outputs.
// TESTING (WIDTH=8, CNT_W=4)
//  1 LSL din=0x96 amt=3 start@E0 -> busy E1..E3 high, q=0xB0 & sout=0 after E3, done=1 for one cycle, busy=0
//  2 ASR din=0x96 amt=2 -> q=0xCB then 0xE5, sout=1, done after E2; ROR din=0x81 amt=1 -> q=0xC0, sout=1
//  3 SIR din=0x00 sin=1 amt=4 -> q=0xF0, sout=0; ROL din=0x81 amt=8 -> q=0x81
//  4 amt=0 din=0x5A -> q=0x5A, busy never high, done pulse after E0; start held high while busy -> ignored, q unaffected
//  5 LSR din=0xFF amt=5, rst=1 after 2 shifts (q=0x3F) -> next edge q=0, busy=0, sout=0, no done pulse ever
//  6 back-to-back: new start in done cycle (ROR 0x01 amt=1) -> accepted, q=0x80 one edge later, second done pulse

Source files
------------

// File: rtl/shift_engine.sv
// Multi-cycle shift/rotate register: parallel load on start, then one shift step
// per clock for a latched count, with busy/done handshake and serial in/out.
module shift_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] amt,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam int N = WIDTH - 1;

    state_t             state, state_n;
    logic [2:0]         mode_r, mode_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   q_n;
    logic               sout_n;
    logic               done_n;
    logic [WIDTH-1:0]   step_q;
    logic               step_out;

    // One shift step of the current register value under the latched mode.
    always_comb begin
        step_q   = q;
        step_out = sout;
        case (mode_r)
            3'd0: begin step_q = {q[N-1:0], 1'b0};  step_out = q[N]; end
            3'd1: begin step_q = {1'b0, q[N:1]};    step_out = q[0]; end
            3'd2: begin step_q = {q[N], q[N:1]};    step_out = q[0]; end
            3'd3: begin step_q = {q[N-1:0], q[N]};  step_out = q[N]; end
            3'd4: begin step_q = {q[0], q[N:1]};    step_out = q[0]; end
            3'd5: begin step_q = {sin, q[N:1]};     step_out = q[0]; end
            default: begin step_q = q;              step_out = sout; end
        endcase
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_n = state;
        q_n     = q;
        sout_n  = sout;
        cnt_n   = cnt;
        mode_n  = mode_r;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    q_n    = din;
                    mode_n = mode;
                    cnt_n  = amt;
                    sout_n = 1'b0;
                    if (amt == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                q_n    = step_q;
                sout_n = step_out;
                cnt_n  = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q      <= '0;
            sout   <= 1'b0;
            cnt    <= '0;
            mode_r <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            q      <= q_n;
            sout   <= sout_n;
            cnt    <= cnt_n;
            mode_r <= mode_n;
            done   <= done_n;
        end
    end

    // Decoded straight from the state flop, so no input reaches it combinationally.
    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_shift_engine.sv
// Directed self-checking bench for shift_engine (WIDTH=8, CNT_W=4) with
// hand-computed expected values checked by immediate assertions.
module tb_shift_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] mode;
    logic [7:0] din;
    logic [3:0] amt;
    logic       sin;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .din   (din),
        .amt   (amt),
        .sin   (sin),
        .q     (q),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] eq, input logic es,
                               input logic eb, input logic ed);
        check({tag, ".q"},    q,    eq);
        check({tag, ".sout"}, sout, es);
        check({tag, ".busy"}, busy, eb);
        check({tag, ".done"}, done, ed);
    endtask

    // Present a start for exactly one edge (E0); returns just after E0.
    task automatic start_op(input logic [2:0] m, input logic [7:0] d, input logic [3:0] a);
        start = 1'b1;
        mode  = m;
        din   = d;
        amt   = a;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 3'd0;
        din   = 8'h00;
        amt   = 4'd0;
        sin   = 1'b0;
        #1;
        tick();
        tick();
        check_state("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_state("idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // LSL 0x96 by 3
        start_op(3'd0, 8'h96, 4'd3);
        check_state("lsl.e0", 8'h96, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("lsl.e1", 8'h2C, 1'b1, 1'b1, 1'b0);
        tick();
        check_state("lsl.e2", 8'h58, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("lsl.e3", 8'hB0, 1'b0, 1'b0, 1'b1);
        tick();
        check_state("lsl.after", 8'hB0, 1'b0, 1'b0, 1'b0);

        // ASR 0x96 by 2
        start_op(3'd2, 8'h96, 4'd2);
        tick();
        check_state("asr.e1", 8'hCB, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("asr.e2", 8'hE5, 1'b1, 1'b0, 1'b1);
        tick();

        // ROR 0x81 by 1
        start_op(3'd4, 8'h81, 4'd1);
        tick();
        check_state("ror.e1", 8'hC0, 1'b1, 1'b0, 1'b1);
        tick();

        // SIR 0x00 with sin=1 by 4
        sin = 1'b1;
        start_op(3'd5, 8'h00, 4'd4);
        tick();
        check("sir.e1.q", q, 8'h80);
        tick();
        tick();
        tick();
        check_state("sir.e4", 8'hF0, 1'b0, 1'b0, 1'b1);
        sin = 1'b0;
        tick();

        // ROL 0x81 by 8 wraps back to the original word
        start_op(3'd3, 8'h81, 4'd8);
        for (int i = 0; i < 7; i++) tick();
        check("rol8.e7.busy", busy, 1'b1);
        tick();
        check_state("rol8.e8", 8'h81, 1'b1, 1'b0, 1'b1);
        tick();

        // LSL 0xFF by 15 saturates to zero
        start_op(3'd0, 8'hFF, 4'd15);
        for (int i = 0; i < 15; i++) tick();
        check_state("lsl15", 8'h00, 1'b0, 1'b0, 1'b1);
        tick();

        // Reserved mode 6 holds q and sout, same timing
        start_op(3'd6, 8'hA5, 4'd3);
        tick();
        tick();
        check_state("rsv.e2", 8'hA5, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("rsv.e3", 8'hA5, 1'b0, 1'b0, 1'b1);
        tick();

        // amt=0: immediate done, never busy
        start_op(3'd0, 8'h5A, 4'd0);
        check_state("amt0.e0", 8'h5A, 1'b0, 1'b0, 1'b1);
        tick();
        check_state("amt0.e1", 8'h5A, 1'b0, 1'b0, 1'b0);

        // start held high while busy is ignored
        start = 1'b1;
        mode  = 3'd0;
        din   = 8'h01;
        amt   = 4'd4;
        tick();
        mode = 3'd1;
        din  = 8'hFF;
        amt  = 4'd2;
        tick();
        tick();
        tick();
        check_state("hold.e3", 8'h08, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        check_state("hold.e4", 8'h10, 1'b0, 1'b0, 1'b1);
        tick();

        // LSR 0xFF by 5 aborted by reset after two shifts
        start_op(3'd1, 8'hFF, 4'd5);
        tick();
        tick();
        check_state("abort.e2", 8'h3F, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        check_state("abort.rst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort.nodone", done, 1'b0);
        end

        // Back-to-back: new start accepted in the done cycle
        start_op(3'd0, 8'h03, 4'd1);
        tick();
        check_state("b2b.first", 8'h06, 1'b0, 1'b0, 1'b1);
        start_op(3'd4, 8'h01, 4'd1);
        check_state("b2b.accept", 8'h01, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("b2b.second", 8'h80, 1'b1, 1'b0, 1'b1);
        tick();
        check("b2b.doneoff", done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
